// File: rtl/ccc_apb_reconfig_if.sv
// Command/response stream between SoC control logic and the CCC reconfiguration block.
// The SoC side uses the master modport and the reconfiguration block uses the slave modport.
interface ccc_apb_reconfig_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/ccc_apb_reconfig.sv
// APB3 initiator for the CCC/PLL dynamic-configuration port, with PLL re-lock sequencing and LOCK supervision.
// Latency: write/read respond 3 cycles after accept; relock responds RST_CYCLES + lock wait + 1 cycles after accept.
// Backpressure: cmd_ready only in IDLE with CCC not busy; responses are single-cycle pulses that cannot be stalled.
module ccc_apb_reconfig #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    ccc_apb_reconfig_if.slave        cmd,
    output logic                     ccc_preset_n,
    output logic                     ccc_psel,
    output logic                     ccc_penable,
    output logic                     ccc_pwrite,
    output logic [5:0]               ccc_paddr,
    output logic [7:0]               ccc_pwdata,
    input  logic [7:0]               ccc_prdata,
    input  logic                     ccc_busy,
    input  logic                     ccc_lock,
    output logic                     pll_arst_n,
    output logic                     lock_ok,
    output logic                     lock_lost
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        PLLRST,
        WAITLOCK,
        RSP
    } state_t;

    localparam logic [1:0]  OP_WRITE  = 2'd0;
    localparam logic [1:0]  OP_RELOCK = 2'd2;
    localparam logic [7:0]  RST_LOAD  = 8'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);

    state_t      state;
    logic [1:0]  op_q;
    logic [7:0]  rst_cnt;
    logic [15:0] to_cnt;
    logic        lock_s1;
    logic        lock_s;
    logic        lock_s_d;
    logic        accept;

    assign cmd.cmd_ready = !reset && (state == IDLE) && !ccc_busy;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign lock_ok       = lock_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            rst_cnt       <= '0;
            to_cnt        <= '0;
            lock_s1       <= 1'b0;
            lock_s        <= 1'b0;
            lock_s_d      <= 1'b0;
            ccc_preset_n  <= 1'b0;
            ccc_psel      <= 1'b0;
            ccc_penable   <= 1'b0;
            ccc_pwrite    <= 1'b0;
            ccc_paddr     <= '0;
            ccc_pwdata    <= '0;
            pll_arst_n    <= 1'b1;
            lock_lost     <= 1'b0;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_rdata <= '0;
            cmd.rsp_error <= 1'b0;
        end else begin
            ccc_preset_n  <= 1'b1;
            lock_s1       <= ccc_lock;
            lock_s        <= lock_s1;
            lock_s_d      <= lock_s;
            cmd.rsp_valid <= 1'b0;

            // A relock accept clears the flag even if lock falls in that same cycle.
            if (accept && cmd.cmd_op == OP_RELOCK) begin
                lock_lost <= 1'b0;
            end else if (lock_s_d && !lock_s && state != PLLRST && state != WAITLOCK) begin
                lock_lost <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= cmd.cmd_op;
                        if (cmd.cmd_op == OP_RELOCK) begin
                            state      <= PLLRST;
                            pll_arst_n <= 1'b0;
                            rst_cnt    <= RST_LOAD;
                        end else begin
                            state       <= SETUP;
                            ccc_psel    <= 1'b1;
                            ccc_penable <= 1'b0;
                            ccc_pwrite  <= (cmd.cmd_op == OP_WRITE);
                            ccc_paddr   <= cmd.cmd_addr;
                            ccc_pwdata  <= cmd.cmd_wdata;
                        end
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    ccc_penable <= 1'b1;
                end
                ACCESS: begin
                    // No PREADY on the CCC port: read data is valid at the end of this single cycle.
                    state         <= RSP;
                    ccc_psel      <= 1'b0;
                    ccc_penable   <= 1'b0;
                    ccc_pwrite    <= 1'b0;
                    cmd.rsp_valid <= 1'b1;
                    cmd.rsp_rdata <= (op_q == OP_WRITE) ? 8'd0 : ccc_prdata;
                    cmd.rsp_error <= 1'b0;
                end
                PLLRST: begin
                    if (rst_cnt == 8'd0) begin
                        state      <= WAITLOCK;
                        pll_arst_n <= 1'b1;
                        to_cnt     <= '0;
                    end else begin
                        rst_cnt <= rst_cnt - 8'd1;
                    end
                end
                WAITLOCK: begin
                    if (lock_s) begin
                        state         <= RSP;
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_rdata <= 8'd0;
                        cmd.rsp_error <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state         <= RSP;
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_rdata <= 8'd0;
                        cmd.rsp_error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
